// File: rtl/rf68000_ring_gateway.sv
// Ring-to-bus gateway: queues requests addressed to this node, runs them
// on the master bus and returns responses on the response ring.
package rf68000_ring_pkg;
    typedef enum logic [3:0] {
        PT_NONE, PT_READ, PT_AREAD, PT_WRITE,
        PT_ACK, PT_AACK, PT_ERR, PT_VPA, PT_RETRY
    } ptyp_t;

    typedef struct packed {
        logic [5:0]  sid;
        logic [5:0]  did;
        logic [5:0]  age;
        logic        ack;
        ptyp_t       typ;
        logic [3:0]  sel;
        logic [7:0]  asid;
        logic        mmus;
        logic        ios;
        logic        iops;
        logic [31:0] adr;
        logic [31:0] dat;
    } packet_t;
endpackage

module rf68000_ring_gateway
    import rf68000_ring_pkg::*;
#(
    parameter int NODE_ID   = 62,
    parameter int AGE_LIMIT = 32,
    parameter int TO_BITS   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  packet_t     packet_i,
    output packet_t     packet_o,
    input  packet_t     rpacket_i,
    output packet_t     rpacket_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [7:0]  m_asid_o,
    output logic [5:0]  m_core_o,
    output logic        m_mmus_o,
    output logic        m_ios_o,
    output logic        m_iops_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic        m_vpa_i,
    input  logic [31:0] m_dat_i,
    output logic [2:0]  fifo_cnt_o,
    output logic [15:0] retry_cnt_o
);
    localparam logic [5:0] NID = 6'(NODE_ID);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [7:0]  asid;
        logic [5:0]  core;
        logic        mmus;
        logic        ios;
        logic        iops;
    } bus_t;

    state_t               state_q, state_d;
    bus_t                 bus_q, bus_d;
    packet_t              pkt_q, pkt_d, rpkt_q, rpkt_d;
    packet_t              rsp_q, rsp_d, req_q, req_d;
    packet_t              fifo_q [4];
    packet_t              fifo_d [4];
    logic                 rsp_valid_q, rsp_valid_d;
    logic [1:0]           rd_q, rd_d, wr_q, wr_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [15:0]          retry_q, retry_d;
    logic [TO_BITS-1:0]   to_q, to_d;
    logic [1:0]           term_q, term_d;
    logic [31:0]          rdat_q, rdat_d;

    logic pop, push, full, emit, resp_load, match, is_req;

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        req_d       = req_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        fifo_d      = fifo_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        to_d        = to_q;
        term_d      = term_q;
        rdat_d      = rdat_q;
        pkt_d       = packet_i;
        rpkt_d      = rpacket_i;
        push        = 1'b0;

        full   = (cnt_q == 3'd4);
        pop    = (state_q == IDLE) && (cnt_q != 3'd0)
                 && !rsp_valid_q && !m_ack_i;
        emit   = rsp_valid_q && (rpacket_i.sid == 6'd0)
                 && (rpacket_i.did == 6'd0);
        resp_load = (state_q == RESP) && (!rsp_valid_q || emit);
        match  = (packet_i.did == NID);
        is_req = (packet_i.typ == PT_READ) || (packet_i.typ == PT_AREAD)
                 || (packet_i.typ == PT_WRITE);

        // response ring: strays die here, pending response fills a hole
        if (rpacket_i.did == NID) begin
            rpkt_d.sid = 6'd0;
            rpkt_d.did = 6'd0;
        end
        if (emit) begin
            rpkt_d      = rsp_q;
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    req_d      = fifo_q[rd_q];
                    rd_d       = rd_q + 2'd1;
                    to_d       = '0;
                    bus_d.cyc  = 1'b1;
                    bus_d.stb  = 1'b1;
                    bus_d.we   = (fifo_q[rd_q].typ == PT_WRITE);
                    bus_d.sel  = bus_d.we ? fifo_q[rd_q].sel : 4'hF;
                    bus_d.adr  = fifo_q[rd_q].adr;
                    bus_d.dat  = fifo_q[rd_q].dat;
                    bus_d.asid = fifo_q[rd_q].asid;
                    bus_d.core = fifo_q[rd_q].sid;
                    bus_d.mmus = fifo_q[rd_q].mmus;
                    bus_d.ios  = fifo_q[rd_q].ios;
                    bus_d.iops = fifo_q[rd_q].iops;
                    state_d    = BUS;
                end
            end
            BUS: begin
                if (m_ack_i || m_err_i || m_vpa_i || (&to_q)) begin
                    bus_d   = '0;
                    state_d = RESP;
                    if (m_ack_i) begin
                        term_d = 2'd0;
                        rdat_d = m_dat_i;
                    end else if (m_err_i) begin
                        term_d = 2'd1;
                    end else if (m_vpa_i) begin
                        term_d = 2'd2;
                    end else begin
                        term_d = 2'd1;
                    end
                end else begin
                    to_d = to_q + TO_BITS'(1);
                end
            end
            RESP: begin
                if (resp_load) begin
                    rsp_d      = '0;
                    rsp_d.sid  = NID;
                    rsp_d.did  = req_q.sid;
                    rsp_d.ack  = 1'b1;
                    rsp_d.adr  = req_q.adr;
                    rsp_d.asid = req_q.asid;
                    rsp_d.mmus = req_q.mmus;
                    rsp_d.ios  = req_q.ios;
                    rsp_d.iops = req_q.iops;
                    case (term_q)
                        2'd0: begin
                            rsp_d.typ = (req_q.typ == PT_AREAD) ? PT_AACK : PT_ACK;
                            rsp_d.dat = rdat_q;
                        end
                        2'd1:    rsp_d.typ = PT_ERR;
                        default: rsp_d.typ = PT_VPA;
                    endcase
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // request ring
        if (match && is_req) begin
            if (!full || pop) begin
                push       = 1'b1;
                pkt_d.sid  = 6'd0;
                pkt_d.did  = 6'd0;
            end else if (int'(packet_i.age) >= AGE_LIMIT
                         && !rsp_valid_q && !resp_load) begin
                pkt_d.sid   = 6'd0;
                pkt_d.did   = 6'd0;
                rsp_d       = '0;
                rsp_d.sid   = NID;
                rsp_d.did   = packet_i.sid;
                rsp_d.ack   = 1'b1;
                rsp_d.typ   = PT_RETRY;
                rsp_d.adr   = packet_i.adr;
                rsp_d.asid  = packet_i.asid;
                rsp_valid_d = 1'b1;
                if (retry_q != 16'hFFFF) retry_d = retry_q + 16'd1;
            end else if (packet_i.age != 6'd63) begin
                pkt_d.age = packet_i.age + 6'd1;
            end
        end else if (match) begin
            pkt_d.sid = 6'd0;
            pkt_d.did = 6'd0;
        end

        if (push) begin
            fifo_d[wr_q] = packet_i;
            wr_d         = wr_q + 2'd1;
        end
        if (push && !pop)      cnt_d = cnt_q + 3'd1;
        else if (pop && !push) cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bus_q       <= '0;
            req_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            to_q        <= '0;
            term_q      <= '0;
            rdat_q      <= '0;
            pkt_q       <= '0;
            rpkt_q      <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            fifo_q      <= fifo_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            to_q        <= to_d;
            term_q      <= term_d;
            rdat_q      <= rdat_d;
            pkt_q       <= pkt_d;
            rpkt_q      <= rpkt_d;
        end
    end

    assign packet_o    = pkt_q;
    assign rpacket_o   = rpkt_q;
    assign m_cyc_o     = bus_q.cyc;
    assign m_stb_o     = bus_q.stb;
    assign m_we_o      = bus_q.we;
    assign m_sel_o     = bus_q.sel;
    assign m_adr_o     = bus_q.adr;
    assign m_dat_o     = bus_q.dat;
    assign m_asid_o    = bus_q.asid;
    assign m_core_o    = bus_q.core;
    assign m_mmus_o    = bus_q.mmus;
    assign m_ios_o     = bus_q.ios;
    assign m_iops_o    = bus_q.iops;
    assign fifo_cnt_o  = cnt_q;
    assign retry_cnt_o = retry_q;
endmodule

// File: tb/tb_rf68000_ring_gateway.sv
// Directed bench for rf68000_ring_gateway: latency, timeout, FIFO
// back-pressure/retry, response insertion, pass-through and reset.
module tb_rf68000_ring_gateway;
    import rf68000_ring_pkg::*;

    logic        clk, rst_n;
    packet_t     pi, po, rpi, rpo;
    logic        cyc, stb, we, mmus, ios, iops;
    logic [3:0]  sel;
    logic [31:0] adr, dato, dati;
    logic [7:0]  asid;
    logic [5:0]  core;
    logic        ack, err, vpa;
    logic [2:0]  fcnt;
    logic [15:0] rcnt;

    int checks = 0;
    int errors = 0;

    rf68000_ring_gateway dut (
        .clk_i(clk), .rst_ni(rst_n),
        .packet_i(pi), .packet_o(po),
        .rpacket_i(rpi), .rpacket_o(rpo),
        .m_cyc_o(cyc), .m_stb_o(stb), .m_we_o(we),
        .m_sel_o(sel), .m_adr_o(adr), .m_dat_o(dato),
        .m_asid_o(asid), .m_core_o(core),
        .m_mmus_o(mmus), .m_ios_o(ios), .m_iops_o(iops),
        .m_ack_i(ack), .m_err_i(err), .m_vpa_i(vpa),
        .m_dat_i(dati),
        .fifo_cnt_o(fcnt), .retry_cnt_o(rcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic packet_t mk(ptyp_t t, logic [5:0] s, logic [5:0] d,
                                   logic [31:0] a, logic [31:0] dt,
                                   logic [3:0] sl, logic [5:0] ag);
        packet_t p;
        p     = '0;
        p.typ = t;
        p.sid = s;
        p.did = d;
        p.adr = a;
        p.dat = dt;
        p.sel = sl;
        p.age = ag;
        return p;
    endfunction

    function automatic logic outs_zero();
        return (po == '0) && (rpo == '0) && !cyc && !stb && !we
            && sel == 4'h0 && adr == 32'h0 && dato == 32'h0
            && asid == 8'h0 && core == 6'h0 && !mmus && !ios && !iops
            && fcnt == 3'd0 && rcnt == 16'd0;
    endfunction

    packet_t occ, tmp;
    int      hi, bad;

    initial begin
        rst_n = 1'b0;
        pi = '0; rpi = '0;
        ack = 0; err = 0; vpa = 0; dati = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'(outs_zero()), 64'd1);
        rst_n = 1'b1;

        // read: push, bus at +1, ack at +2, response on ring at +4
        @(negedge clk);
        pi = mk(PT_READ, 6'd5, 6'd62, 32'h2000_0010, 32'h0, 4'h0, 6'd0);
        @(negedge clk);
        pi = '0;
        chk("rd_push_clear", 64'({po.sid, po.did}), 64'd0);
        chk("rd_fifo1", 64'(fcnt), 64'd1);
        @(negedge clk);
        chk("rd_cyc", 64'({cyc, stb, we, sel}), 64'b1_1_0_1111);
        chk("rd_adr_core", {adr, 26'h0, core}, {32'h2000_0010, 26'h0, 6'd5});
        ack = 1; dati = 32'hDEAD_BEEF;
        @(negedge clk);
        ack = 0;
        chk("rd_cyc_drop", 64'(cyc), 64'd0);
        @(negedge clk);
        chk("rd_rsp_not_yet", 64'(rpo.did), 64'd0);
        @(negedge clk);
        chk("rd_rsp_typ", 64'(rpo.typ), 64'(PT_ACK));
        chk("rd_rsp_ids", 64'({rpo.sid, rpo.did, rpo.ack}), 64'({6'd62, 6'd5, 1'b1}));
        chk("rd_rsp_dat", {rpo.adr, rpo.dat}, {32'h2000_0010, 32'hDEAD_BEEF});

        // write that never terminates -> 256-cycle timeout -> PT_ERR
        pi = mk(PT_WRITE, 6'd3, 6'd62, 32'h0000_0100, 32'h1234, 4'h3, 6'd0);
        @(negedge clk);
        pi = '0;
        @(negedge clk);
        chk("wr_bus", {cyc, we, sel, 26'h0, dato},
            {1'b1, 1'b1, 4'h3, 26'h0, 32'h1234});
        hi = 1;
        while (cyc && hi < 400) begin
            @(negedge clk);
            if (cyc) hi++;
        end
        chk("wr_timeout_len", 64'(hi), 64'd256);
        @(negedge clk);
        chk("wr_rsp_not_yet", 64'(rpo.did), 64'd0);
        @(negedge clk);
        chk("wr_rsp_err", 64'({rpo.typ, rpo.did}), 64'({PT_ERR, 6'd3}));

        // six back-to-back reads against a stalled bus
        for (int i = 0; i < 6; i++) begin
            pi = mk(PT_READ, 6'(10 + i), 6'd62, 32'h100 + 32'(i), 32'h0, 4'h0, 6'd0);
            @(negedge clk);
        end
        pi = mk(PT_READ, 6'd15, 6'd62, 32'h105, 32'h0, 4'h0, 6'd31);
        chk("full_cnt", 64'(fcnt), 64'd4);
        chk("full_pass_age", 64'({po.sid, po.did, po.age}),
            64'({6'd15, 6'd62, 6'd1}));
        @(negedge clk);
        pi = mk(PT_READ, 6'd15, 6'd62, 32'h105, 32'h0, 4'h0, 6'd32);
        chk("age31_pass", 64'({po.did, po.age}), 64'({6'd62, 6'd32}));
        @(negedge clk);
        pi = '0;
        chk("retry_drop", 64'({po.sid, po.did}), 64'd0);
        chk("retry_cnt", 64'(rcnt), 64'd1);
        @(negedge clk);
        chk("retry_rsp", {20'h0, rpo.typ, rpo.sid, rpo.did, rpo.adr},
            {20'h0, PT_RETRY, 6'd62, 6'd15, 32'h105});

        // response held back while the response ring is occupied
        occ = mk(PT_ACK, 6'd1, 6'd2, 32'h77, 32'h99, 4'h0, 6'd0);
        rpi = occ;
        ack = 1; dati = 32'h55;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ack = 0;
            if (rpo != occ) bad++;
        end
        chk("occ_intact", 64'(bad), 64'd0);
        chk("occ_no_pop", 64'({cyc, fcnt}), 64'({1'b0, 3'd4}));
        rpi = '0;
        @(negedge clk);
        chk("occ_insert", {20'h0, rpo.typ, rpo.did, rpo.dat},
            {20'h0, PT_ACK, 6'd10, 32'h55});

        // next request to bus, ack it, then wait for the one after
        hi = 0;
        while (!cyc && hi < 10) begin @(negedge clk); hi++; end
        chk("pop2_core", 64'({cyc, core}), 64'({1'b1, 6'd11}));
        ack = 1;
        @(negedge clk);
        ack = 0;
        @(negedge clk);
        hi = 0;
        while (!cyc && hi < 10) begin @(negedge clk); hi++; end
        chk("pop3_state", 64'({cyc, core, fcnt}), 64'({1'b1, 6'd12, 3'd2}));

        // asynchronous reset mid bus cycle
        #2 rst_n = 1'b0;
        #1 chk("midrst_outs", 64'(outs_zero()), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc || rpo != '0 || fcnt != 3'd0) bad++;
        end
        chk("post_rst_quiet", 64'(bad), 64'd0);

        // pass-through of foreign and broadcast traffic
        tmp = mk(PT_READ, 6'd4, 6'd63, 32'hAAAA_0000, 32'h1, 4'h1, 6'd5);
        pi = tmp;
        @(negedge clk);
        chk("bcast_pass", 64'(po == tmp), 64'd1);
        tmp = mk(PT_WRITE, 6'd9, 6'd7, 32'hBBBB_0000, 32'h2, 4'h2, 6'd6);
        pi = tmp;
        @(negedge clk);
        chk("did7_pass", 64'(po == tmp), 64'd1);
        pi = mk(PT_ACK, 6'd9, 6'd62, 32'h0, 32'h0, 4'h0, 6'd0);
        rpi = mk(PT_ACK, 6'd8, 6'd62, 32'h0, 32'h0, 4'h0, 6'd0);
        @(negedge clk);
        pi = '0; rpi = '0;
        chk("nonreq_removed", 64'({po.sid, po.did, fcnt}), 64'd0);
        chk("stray_removed", 64'({rpo.sid, rpo.did}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
